sram_1w1r_param: RTL and testbench
==================================

// Module: sram_1w1r_param
// PURPOSE
// Parametrised, synthesizable single-clock 1-write/1-read SRAM macro model; successor to fixed-size OpenRAM 1w1r models.
// Adds: arbitrary width/depth/write-mask granularity, registered read with valid strobe,
// same-address read-during-write bypass, collision flag, optional zero-fill sequencer after reset.
// Sits between on-chip buffers (FIFOs, line buffers) and the physical SRAM macro behind the same port set.
// PARAMETERS
// DATA_WIDTH     64  data bits per word
// ADDR_WIDTH     5   address bits; RAM_DEPTH = 1<<ADDR_WIDTH
// NUM_WMASKS     2   write-mask lanes; lane width = DATA_WIDTH/NUM_WMASKS
// BYPASS         1   1: same-address read returns new write data per masked lane; 0: returns old data
// CLEAR_ON_RESET 1   1: zero-fill every word after reset; 0: contents undefined, ready immediately
// PORTS
// clk0        in   1             single clock, both ports, rising edge
// rstb0       in   1             asynchronous reset, active low
// csb0        in   1             write port select, active low
// wmask0      in   NUM_WMASKS    per-lane write enable, active high
// addr0       in   ADDR_WIDTH    write address
// din0        in   DATA_WIDTH    write data
// csb1        in   1             read port select, active low
// addr1       in   ADDR_WIDTH    read address
// dout1       out  DATA_WIDTH    registered read data
// dout1_valid out  1             one-cycle strobe, dout1 updated this cycle
// collision1  out  1             one-cycle strobe: previous cycle read and write hit same address, mask!=0
// ready       out  1             high when ports accepted (init complete)
// BEHAVIOUR
// - One clock clk0; rstb0 asynchronous, active low. Reset: dout1=0, dout1_valid=0, collision1=0, ready=0, FSM=INIT, init_addr=0.
// - FSM INIT -> READY. INIT (CLEAR_ON_RESET=1): one word/cycle mem[init_addr]=0, init_addr++; after address
//   RAM_DEPTH-1 written, next edge -> READY; ready=1 from cycle RAM_DEPTH+1 after rstb0 release.
//   CLEAR_ON_RESET=0: INIT lasts one cycle, ready=1 first edge after release. csb0/csb1 ignored while ready=0.
// - Reset mid-INIT: sequencer restarts at address 0; partial zeroing not trusted. Reset in READY: contents preserved
//   unless CLEAR_ON_RESET=1 (refilled).
// - Write (ready & !csb0 at edge): mem[addr0] lane i <= din0 lane i for every wmask0[i]=1; other lanes unchanged;
//   wmask0=0 is a no-op. Visible to a read issued the following cycle.
// - Read (ready & !csb1 at edge t): dout1 valid after edge t+1 (latency 1), dout1_valid=1 that cycle only.
//   csb1=1: dout1 holds last value, dout1_valid=0.
// - Same edge, !csb0 & !csb1 & addr0==addr1 & |wmask0: BYPASS=1 -> masked lanes from din0, unmasked lanes old mem;
//   BYPASS=0 -> all lanes old mem. Either case collision1=1 with dout1_valid. Write always completes.
// - Address wrap: addr fully decoded, no out-of-range; init_addr wraps only at FSM exit.
// - Elaboration: DATA_WIDTH % NUM_WMASKS != 0 or NUM_WMASKS<1 -> $error; no X on any output after reset.
// STRUCTURE
// - Package sram_pkg: typedef enum {ST_INIT, ST_READY} sram_state_t; function lane_width(dw,nm); LANE localparam.
// - Sub-module sram_1w1r_array: pure storage, no reset, registered read port, per-lane write; top holds FSM,
//   init mux onto write port, bypass/collision compare pipeline register and output merge.
// TESTING
// - Reset release, CLEAR_ON_RESET=1, depth 32 -> ready rises exactly 33 cycles later; read all 32 addrs -> 0.
// - Write addr 3 din=64'hAAAA_BBBB_CCCC_DDDD mask=2'b11; next cycle read 3 -> dout1 matches, valid 1 cycle later.
// - Prefill addr 5=all F; write addr 5 din=0 mask=2'b01 -> read returns 64'hFFFF_FFFF_0000_0000.
// - Same-cycle write/read addr 7, old=0, din=64'h1111_2222_3333_4444, mask=2'b10: BYPASS=1 ->
//   64'h1111_2222_0000_0000, BYPASS=0 -> 0; collision1=1; next read addr 7 -> 64'h1111_2222_0000_0000.
// - Assert rstb0 at init_addr=12 for 1 cycle -> ready low, refill restarts, ready 33 cycles after release.
// - csb0/csb1 toggled while ready=0 -> no write effect, dout1_valid stays 0; csb1=1 in READY -> dout1 holds.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1w1r SRAM model.
package sram_pkg;

    // Sequencer states: zero-fill after reset, then accepting traffic.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_t;

    // Bits per write-mask lane; a zero lane count is rejected at elaboration by the top.
    function automatic int unsigned lane_width(input int unsigned dw, input int unsigned nm);
        return (nm == 0) ? dw : dw / nm;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_NUM_WMASKS = 2;
    localparam int unsigned LANE           = lane_width(DEF_DATA_WIDTH, DEF_NUM_WMASKS);

endpackage

// File: rtl/sram_1w1r_param_if.sv
// Write port, read port and status signals of the 1w1r SRAM model.
interface sram_1w1r_param_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_WMASKS = 2
) ();
    logic                  csb0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  collision1;
    logic                  ready;

    modport master (
        output csb0, wmask0, addr0, din0, csb1, addr1,
        input  dout1, dout1_valid, collision1, ready
    );

    modport slave (
        input  csb0, wmask0, addr0, din0, csb1, addr1,
        output dout1, dout1_valid, collision1, ready
    );
endinterface

// File: rtl/sram_1w1r_array.sv
// Pure storage: per-lane write port and registered read port, no reset.
module sram_1w1r_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_WMASKS = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned LANE_W = lane_width(DATA_WIDTH, NUM_WMASKS);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    // Each lane is its own array so that every storage element has a single driver.
    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rdata_q;

        // Lane write and registered read; a same-address read returns the pre-write word.
        always_ff @(posedge clk) begin
            if (we && wmask[g]) begin
                mem[waddr] <= wdata[g*LANE_W +: LANE_W];
            end
            if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata[g*LANE_W +: LANE_W] = rdata_q;
    end
endmodule

// File: rtl/sram_1w1r_param.sv
// Parametrised 1w1r SRAM: zero-fill sequencer, read bypass/collision pipeline, output merge.
module sram_1w1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NUM_WMASKS     = 2,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk0,
    input  logic                rstb0,
    sram_1w1r_param_if.slave    bus
);
    localparam int unsigned LANE_W = lane_width(DATA_WIDTH, NUM_WMASKS);

    if ((NUM_WMASKS < 1) || ((DATA_WIDTH % ((NUM_WMASKS < 1) ? 1 : NUM_WMASKS)) != 0)) begin : g_bad_cfg
        $error("sram_1w1r_param: DATA_WIDTH must be a multiple of NUM_WMASKS and NUM_WMASKS >= 1");
    end

    sram_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                  init_done_q, init_done_d;
    logic                  valid_q, valid_d;
    logic                  coll_q, coll_d;
    logic                  have_q, have_d;
    logic [NUM_WMASKS-1:0] byp_mask_q, byp_mask_d;
    logic [DATA_WIDTH-1:0] byp_din_q, byp_din_d;

    logic                  ready, rd_en, wr_en, hit;
    logic                  arr_we;
    logic [NUM_WMASKS-1:0] arr_mask;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data, arr_rdata, merged;

    assign ready = (state_q == ST_READY);
    assign rd_en = ready && !bus.csb1;
    assign wr_en = ready && !bus.csb0;
    assign hit   = wr_en && rd_en && (bus.addr0 == bus.addr1) && (|bus.wmask0);

    // Sequencer: one zeroed word per cycle; after the last word, a single extra cycle before READY.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if ((CLEAR_ON_RESET == 0) || init_done_q) begin
                    state_d     = ST_READY;
                    init_addr_d = '0;
                    init_done_d = 1'b0;
                end else if (init_addr_q == '1) begin
                    init_done_d = 1'b1;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Write-port mux: the zero-fill owns the array until READY, user traffic after.
    always_comb begin
        arr_we   = wr_en;
        arr_mask = bus.wmask0;
        arr_addr = bus.addr0;
        arr_data = bus.din0;
        if (state_q == ST_INIT) begin
            arr_we   = (CLEAR_ON_RESET != 0) && !init_done_q;
            arr_mask = '1;
            arr_addr = init_addr_q;
            arr_data = '0;
        end
    end

    // Read-side pipeline: strobes plus the lanes/data to overlay on the array output.
    always_comb begin
        valid_d    = rd_en;
        coll_d     = hit;
        have_d     = have_q || rd_en;
        byp_mask_d = byp_mask_q;
        byp_din_d  = byp_din_q;
        if (rd_en) begin
            byp_mask_d = ((BYPASS != 0) && hit) ? bus.wmask0 : '0;
            byp_din_d  = bus.din0;
        end
    end

    // State and pipeline registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            coll_q      <= 1'b0;
            have_q      <= 1'b0;
            byp_mask_q  <= '0;
            byp_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
            valid_q     <= valid_d;
            coll_q      <= coll_d;
            have_q      <= have_d;
            byp_mask_q  <= byp_mask_d;
            byp_din_q   <= byp_din_d;
        end
    end

    sram_1w1r_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_array (
        .clk   (clk0),
        .we    (arr_we),
        .wmask (arr_mask),
        .waddr (arr_addr),
        .wdata (arr_data),
        .re    (rd_en),
        .raddr (bus.addr1),
        .rdata (arr_rdata)
    );

    // The array read register has no reset, so dout1 is forced to zero until the first read;
    // holding works because the array register and the overlay only load on a read.
    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_merge
        assign merged[g*LANE_W +: LANE_W] = byp_mask_q[g] ? byp_din_q[g*LANE_W +: LANE_W]
                                                          : arr_rdata[g*LANE_W +: LANE_W];
    end

    assign bus.dout1       = have_q ? merged : '0;
    assign bus.dout1_valid = valid_q;
    assign bus.collision1  = coll_q;
    assign bus.ready       = ready;
endmodule

// File: tb/tb_sram_1w1r_param.sv
// Scoreboard bench: BYPASS=1 and BYPASS=0 instances driven with identical directed vectors.
module tb_sram_1w1r_param;

    logic        clk0 = 1'b0;
    logic        rstb0 = 1'b0;
    logic        csb0 = 1'b1;
    logic        csb1 = 1'b1;
    logic [1:0]  wmask0 = '0;
    logic [4:0]  addr0 = '0;
    logic [4:0]  addr1 = '0;
    logic [63:0] din0 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] data;
        logic        coll;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk0 = ~clk0;

    sram_1w1r_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_WMASKS(2)) if_b1 ();
    sram_1w1r_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_WMASKS(2)) if_b0 ();

    assign if_b1.csb0 = csb0;  assign if_b0.csb0 = csb0;
    assign if_b1.wmask0 = wmask0;  assign if_b0.wmask0 = wmask0;
    assign if_b1.addr0 = addr0;  assign if_b0.addr0 = addr0;
    assign if_b1.din0 = din0;  assign if_b0.din0 = din0;
    assign if_b1.csb1 = csb1;  assign if_b0.csb1 = csb1;
    assign if_b1.addr1 = addr1;  assign if_b0.addr1 = addr1;

    sram_1w1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_WMASKS(2), .BYPASS(1), .CLEAR_ON_RESET(1))
        dut_b1 (.clk0(clk0), .rstb0(rstb0), .bus(if_b1.slave));
    sram_1w1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_WMASKS(2), .BYPASS(0), .CLEAR_ON_RESET(1))
        dut_b0 (.clk0(clk0), .rstb0(rstb0), .bus(if_b0.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation per dout1_valid strobe on each instance.
    always begin
        exp_t e;
        @(posedge clk0);
        #1;
        if (if_b1.dout1_valid !== 1'b0) begin
            if (q1.size() == 0) check("b1 unexpected dout1_valid", 64'(if_b1.dout1_valid), 64'd0);
            else begin
                e = q1.pop_front();
                check("b1 dout1", if_b1.dout1, e.data);
                check("b1 collision1", 64'(if_b1.collision1), 64'(e.coll));
            end
        end else if (if_b1.collision1 !== 1'b0) begin
            check("b1 collision1 without valid", 64'(if_b1.collision1), 64'd0);
        end
        if (if_b0.dout1_valid !== 1'b0) begin
            if (q0.size() == 0) check("b0 unexpected dout1_valid", 64'(if_b0.dout1_valid), 64'd0);
            else begin
                e = q0.pop_front();
                check("b0 dout1", if_b0.dout1, e.data);
                check("b0 collision1", 64'(if_b0.collision1), 64'(e.coll));
            end
        end else if (if_b0.collision1 !== 1'b0) begin
            check("b0 collision1 without valid", 64'(if_b0.collision1), 64'd0);
        end
    end

    // One cycle of traffic; inputs change 1 time unit after the edge.
    task automatic op(input logic we, input logic [1:0] m, input logic [4:0] wa, input logic [63:0] d,
                      input logic re, input logic [4:0] ra,
                      input logic [63:0] e1, input logic [63:0] e0, input logic c);
        csb0 = !we; wmask0 = m; addr0 = wa; din0 = d;
        csb1 = !re; addr1 = ra;
        if (re) begin
            q1.push_back('{data: e1, coll: c});
            q0.push_back('{data: e0, coll: c});
        end
        @(posedge clk0);
        #1;
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
    endtask

    // Count edges after release until ready, hammering both ports meanwhile.
    task automatic wait_ready(input string name);
        int cnt = 0;
        while (cnt < 100) begin
            csb0 = cnt[0]; csb1 = !cnt[0];
            wmask0 = '1; addr0 = 5'd3; addr1 = 5'd3; din0 = '1;
            @(posedge clk0);
            #1;
            cnt++;
            if (if_b1.ready === 1'b1) break;
        end
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; din0 = '0;
        check(name, 64'(cnt), 64'd33);
        check({name, " b0"}, 64'(if_b0.ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk0);
        #1;
        check("reset dout1", if_b1.dout1, 64'd0);
        check("reset dout1_valid", 64'(if_b1.dout1_valid), 64'd0);
        check("reset collision1", 64'(if_b1.collision1), 64'd0);
        check("reset ready", 64'(if_b1.ready), 64'd0);
        rstb0 = 1'b1;
        wait_ready("ready latency after reset");

        for (int a = 0; a < 32; a++) op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'(a), 64'd0, 64'd0, 1'b0);

        op(1'b1, 2'b11, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);

        op(1'b1, 2'b11, 5'd5, '1, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        op(1'b1, 2'b01, 5'd5, 64'd0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);

        op(1'b1, 2'b10, 5'd7, 64'h1111_2222_3333_4444, 1'b1, 5'd7, 64'h1111_2222_0000_0000, 64'd0, 1'b1);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd7, 64'h1111_2222_0000_0000, 64'h1111_2222_0000_0000, 1'b0);
        op(1'b1, 2'b00, 5'd7, '1, 1'b1, 5'd7, 64'h1111_2222_0000_0000, 64'h1111_2222_0000_0000, 1'b0);

        op(1'b1, 2'b11, 5'd9, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd3, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd9, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);

        repeat (3) op(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        check("b1 dout1 hold", if_b1.dout1, 64'h0123_4567_89AB_CDEF);
        check("b0 dout1 hold", if_b0.dout1, 64'h0123_4567_89AB_CDEF);

        rstb0 = 1'b0;
        #1;
        check("reset in READY dout1", if_b1.dout1, 64'd0);
        check("reset in READY ready", 64'(if_b1.ready), 64'd0);
        @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        repeat (12) @(posedge clk0);
        #1;
        check("mid-init ready low", 64'(if_b1.ready), 64'd0);
        rstb0 = 1'b0;
        @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        wait_ready("ready latency after mid-init reset");

        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd3, 64'd0, 64'd0, 1'b0);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd9, 64'd0, 64'd0, 1'b0);
        op(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 5'd31, 64'd0, 64'd0, 1'b0);

        repeat (3) op(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        check("b1 pending reads", 64'(q1.size()), 64'd0);
        check("b0 pending reads", 64'(q0.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
